// File: rtl/umem_port_arbiter.sv
// Two-requester arbiter for the single umem port: IF reads and LS reads/writes
// are serialised into one registered req/gnt/rvalid transaction at a time.
module umem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_rw,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_last_ls, w_last_ls_nxt;
  logic              r_win_ls, w_win_ls_nxt;
  logic              w_pick_ls;

  logic              r_if_gnt, w_if_gnt_nxt;
  logic              r_ls_gnt, w_ls_gnt_nxt;
  logic              r_if_rvalid, w_if_rvalid_nxt;
  logic              r_ls_rvalid, w_ls_rvalid_nxt;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
  logic [DATA_W-1:0] r_ls_rdata, w_ls_rdata_nxt;
  logic              r_mem_en, w_mem_en_nxt;
  logic              r_mem_rw, w_mem_rw_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;

  // Round-robin: on a conflict the side that did not win last time takes it
  assign w_pick_ls = ls_req & (~if_req | ~r_last_ls);

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_ls   <= 1'b0;
      r_win_ls    <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_ls_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_ls   <= w_last_ls_nxt;
      r_win_ls    <= w_win_ls_nxt;
      r_if_gnt    <= w_if_gnt_nxt;
      r_ls_gnt    <= w_ls_gnt_nxt;
      r_if_rvalid <= w_if_rvalid_nxt;
      r_ls_rvalid <= w_ls_rvalid_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_ls_rdata  <= w_ls_rdata_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_rw    <= w_mem_rw_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  // Next-state and next-output logic; memory command lives in r_mem_* from ISSUE on
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_ls_nxt   = r_last_ls;
    w_win_ls_nxt    = r_win_ls;
    w_if_gnt_nxt    = 1'b0;
    w_ls_gnt_nxt    = 1'b0;
    w_if_rvalid_nxt = 1'b0;
    w_ls_rvalid_nxt = 1'b0;
    w_mem_en_nxt    = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_ls_rdata_nxt  = r_ls_rdata;
    w_mem_rw_nxt    = r_mem_rw;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (if_req || ls_req) begin
          w_win_ls_nxt    = w_pick_ls;
          w_last_ls_nxt   = w_pick_ls;
          w_if_gnt_nxt    = ~w_pick_ls;
          w_ls_gnt_nxt    = w_pick_ls;
          w_mem_en_nxt    = 1'b1;
          w_mem_rw_nxt    = w_pick_ls & ls_rw;
          w_mem_addr_nxt  = w_pick_ls ? ls_addr : if_addr;
          w_mem_wdata_nxt = (w_pick_ls && ls_rw) ? ls_wdata : '0;
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_mem_rw) begin
          // Write committed this cycle; completion carries zero data
          w_if_rvalid_nxt = ~r_win_ls;
          w_ls_rvalid_nxt = r_win_ls;
          if (r_win_ls) w_ls_rdata_nxt = '0;
          else          w_if_rdata_nxt = '0;
          w_state_nxt     = S_DONE;
        end else begin
          w_cnt_nxt   = CNT_W'(MEM_LAT);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_if_rvalid_nxt = ~r_win_ls;
          w_ls_rvalid_nxt = r_win_ls;
          if (r_win_ls) w_ls_rdata_nxt = mem_rdata;
          else          w_if_rdata_nxt = mem_rdata;
          w_state_nxt     = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign if_gnt    = r_if_gnt;
  assign ls_gnt    = r_ls_gnt;
  assign if_rvalid = r_if_rvalid;
  assign ls_rvalid = r_ls_rvalid;
  assign if_rdata  = r_if_rdata;
  assign ls_rdata  = r_ls_rdata;
  assign mem_en    = r_mem_en;
  assign mem_rw    = r_mem_rw;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_umem_port_arbiter.sv
// Bench for umem_port_arbiter: three instances (MEM_LAT 1, 2, 4), each with its own
// umem model, checked every cycle against a transaction-timeline reference model.
module tb_umem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int NL = 3;

  logic clk = 1'b0;
  logic rst;

  logic          if_req    [NL];
  logic [AW-1:0] if_addr   [NL];
  logic          if_gnt    [NL];
  logic          if_rvalid [NL];
  logic [DW-1:0] if_rdata  [NL];
  logic          ls_req    [NL];
  logic          ls_rw     [NL];
  logic [AW-1:0] ls_addr   [NL];
  logic [DW-1:0] ls_wdata  [NL];
  logic          ls_gnt    [NL];
  logic          ls_rvalid [NL];
  logic [DW-1:0] ls_rdata  [NL];
  logic          mem_en    [NL];
  logic          mem_rw    [NL];
  logic [AW-1:0] mem_addr  [NL];
  logic [DW-1:0] mem_wdata [NL];
  logic [DW-1:0] mem_rdata [NL];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    umem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .nreset(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .ls_req(ls_req[g]), .ls_rw(ls_rw[g]), .ls_addr(ls_addr[g]), .ls_wdata(ls_wdata[g]),
      .ls_gnt(ls_gnt[g]), .ls_rvalid(ls_rvalid[g]), .ls_rdata(ls_rdata[g]),
      .mem_en(mem_en[g]), .mem_rw(mem_rw[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
  end

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: one pending transaction per lane, described by event cycles
  int          m_tg   [NL];
  int          m_trv  [NL];
  int          m_free [NL];
  bit          m_last [NL];
  bit          m_wls  [NL];
  logic        m_rw   [NL];
  logic [31:0] m_addr [NL];
  logic [31:0] m_wd   [NL];
  logic [31:0] m_res  [NL];
  logic        e_rw   [NL];
  logic [31:0] e_addr [NL];
  logic [31:0] e_wd   [NL];
  logic [31:0] e_ifd  [NL];
  logic [31:0] e_lsd  [NL];
  logic [31:0] ref_mem [NL][16];
  logic [31:0] umem    [NL][16];
  int          pend_cyc  [NL];
  logic [31:0] pend_data [NL];

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : (l == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] rand_addr();
    return $urandom & 32'h0F00_003C;
  endfunction

  task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane=%0d cyc=%0d got=0x%08h exp=0x%08h", name, l, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int l);
    m_tg[l] = -1; m_trv[l] = -1; m_free[l] = 0; m_last[l] = 1'b0; m_wls[l] = 1'b0;
    e_rw[l] = 1'b0; e_addr[l] = '0; e_wd[l] = '0; e_ifd[l] = '0; e_lsd[l] = '0;
    pend_cyc[l] = -1;
  endtask

  task automatic model_step();
    for (int l = 0; l < NL; l++) begin
      int  ix;
      bit  pick;
      bit  hit;
      if (rst) model_reset(l);
      else begin
        if (cyc == m_tg[l]) begin
          ix = int'(m_addr[l][5:2]);
          e_rw[l] = m_rw[l]; e_addr[l] = m_addr[l]; e_wd[l] = m_rw[l] ? m_wd[l] : 32'h0;
          if (m_rw[l]) ref_mem[l][ix] = m_wd[l];
          m_res[l] = m_rw[l] ? 32'h0 : ref_mem[l][ix];
        end
        if (cyc == m_trv[l]) begin
          if (m_wls[l]) e_lsd[l] = m_res[l];
          else          e_ifd[l] = m_res[l];
        end
      end
      chk("if_gnt",    l, 32'(if_gnt[l]),    32'(cyc == m_tg[l]  && !m_wls[l]));
      chk("ls_gnt",    l, 32'(ls_gnt[l]),    32'(cyc == m_tg[l]  &&  m_wls[l]));
      chk("if_rvalid", l, 32'(if_rvalid[l]), 32'(cyc == m_trv[l] && !m_wls[l]));
      chk("ls_rvalid", l, 32'(ls_rvalid[l]), 32'(cyc == m_trv[l] &&  m_wls[l]));
      chk("mem_en",    l, 32'(mem_en[l]),    32'(cyc == m_tg[l]));
      chk("mem_rw",    l, 32'(mem_rw[l]),    32'(e_rw[l]));
      chk("mem_addr",  l, mem_addr[l],  e_addr[l]);
      chk("mem_wdata", l, mem_wdata[l], e_wd[l]);
      chk("if_rdata",  l, if_rdata[l],  e_ifd[l]);
      chk("ls_rdata",  l, ls_rdata[l],  e_lsd[l]);
      // Arbitrate a new transaction when the model lane is idle
      if (!rst && cyc >= m_free[l] && (if_req[l] || ls_req[l])) begin
        pick = ls_req[l] && (!if_req[l] || !m_last[l]);
        m_last[l] = pick; m_wls[l] = pick;
        m_rw[l]   = pick ? ls_rw[l] : 1'b0;
        m_addr[l] = pick ? ls_addr[l] : if_addr[l];
        m_wd[l]   = ls_wdata[l];
        m_tg[l]   = cyc + 1;
        m_trv[l]  = m_rw[l] ? cyc + 2 : cyc + 2 + lat_of(l);
        m_free[l] = m_trv[l] + 1;
      end
      // umem behaviour: writes commit on mem_en, reads return data MEM_LAT cycles later
      hit = (cyc == pend_cyc[l]);
      mem_rdata[l] = hit ? pend_data[l] : $urandom;
      if (!rst && mem_en[l]) begin
        ix = int'(mem_addr[l][5:2]);
        if (mem_rw[l]) umem[l][ix] = mem_wdata[l];
        else begin
          pend_cyc[l]  = cyc + lat_of(l);
          pend_data[l] = umem[l][ix];
        end
      end
    end
  endtask

  // Directed transaction on one lane with hand-computed rvalid cycle
  task automatic lit_txn(input int l, input bit is_ls, input bit rw, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input int exp_rv);
    if (is_ls) begin
      ls_req[l] = 1'b1; ls_rw[l] = rw; ls_addr[l] = addr; ls_wdata[l] = wdata;
    end else begin
      if_req[l] = 1'b1; if_addr[l] = addr;
    end
    @(negedge clk);
    chk("lit_gnt",      l, 32'(is_ls ? ls_gnt[l] : if_gnt[l]), 32'h1);
    chk("lit_mem_en",   l, 32'(mem_en[l]), 32'h1);
    chk("lit_mem_rw",   l, 32'(mem_rw[l]), 32'(rw));
    chk("lit_mem_addr", l, mem_addr[l], addr);
    chk("lit_mem_wd",   l, mem_wdata[l], rw ? wdata : 32'h0);
    if_req[l] = 1'b0; ls_req[l] = 1'b0;
    for (int c = 2; c < exp_rv; c++) begin
      @(negedge clk);
      chk("lit_rv_early", l, 32'(is_ls ? ls_rvalid[l] : if_rvalid[l]), 32'h0);
    end
    @(negedge clk);
    chk("lit_rvalid", l, 32'(is_ls ? ls_rvalid[l] : if_rvalid[l]), 32'h1);
    chk("lit_rdata",  l, is_ls ? ls_rdata[l] : if_rdata[l], exp_rd);
    @(negedge clk);
    chk("lit_idle_rv",  l, 32'(is_ls ? ls_rvalid[l] : if_rvalid[l]), 32'h0);
    chk("lit_idle_gnt", l, 32'(if_gnt[l] | ls_gnt[l]), 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    int seq, ngr, first;
    rst = 1'b1;
    for (int l = 0; l < NL; l++) begin
      if_req[l] = 1'b0; if_addr[l] = '0; ls_req[l] = 1'b0; ls_rw[l] = 1'b0;
      ls_addr[l] = '0; ls_wdata[l] = '0; mem_rdata[l] = '0;
      for (int i = 0; i < 16; i++) begin
        v = $urandom;
        ref_mem[l][i] = v; umem[l][i] = v;
      end
      ref_mem[l][4] = 32'hDEADBEEF; umem[l][4] = 32'hDEADBEEF;
      model_reset(l);
    end
    fork
      forever begin @(posedge clk); cyc++; end
      forever begin @(negedge clk); #1; model_step(); end
    join_none

    repeat (3) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      chk("rst_gnt",   l, 32'(if_gnt[l] | ls_gnt[l]), 32'h0);
      chk("rst_mem_en", l, 32'(mem_en[l]), 32'h0);
      chk("rst_addr",  l, mem_addr[l], 32'h0);
    end
    rst = 1'b0;

    lit_txn(1, 1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 4);
    lit_txn(1, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0,        2);
    lit_txn(1, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 32'h0,        2);
    lit_txn(1, 1'b1, 1'b0, 32'h20, 32'h0,        32'hA5A5A5A5, 4);
    lit_txn(0, 1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 3);
    lit_txn(2, 1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 6);

    // Both requesters held from reset release: grants must alternate LS, IF, LS, IF
    rst = 1'b1;
    @(negedge clk);
    if_req[1] = 1'b1; if_addr[1] = 32'h04;
    ls_req[1] = 1'b1; ls_rw[1] = 1'b0; ls_addr[1] = 32'h08;
    rst = 1'b0;
    seq = 0; ngr = 0; first = -1;
    for (int n = 0; n < 40 && ngr < 4; n++) begin
      @(negedge clk);
      chk("dual_gnt", 1, 32'(if_gnt[1] & ls_gnt[1]), 32'h0);
      if (if_gnt[1] || ls_gnt[1]) begin
        if (first < 0) first = n + 1;
        seq = (seq << 1) | int'(ls_gnt[1]);
        ngr++;
      end
    end
    chk("rr_count", 1, 32'(ngr), 32'd4);
    chk("rr_order", 1, 32'(seq), 32'b1010);
    chk("rr_first_gnt_cyc", 1, 32'(first), 32'd1);
    if_req[1] = 1'b0; ls_req[1] = 1'b0;
    repeat (10) @(negedge clk);

    // Reset during WAIT of an IF read abandons it
    if_req[1] = 1'b1; if_addr[1] = 32'h10;
    @(negedge clk);
    if_req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_gnt",    1, 32'(if_gnt[1] | ls_gnt[1]), 32'h0);
    chk("arst_rvalid", 1, 32'(if_rvalid[1] | ls_rvalid[1]), 32'h0);
    chk("arst_mem_en", 1, 32'(mem_en[1]), 32'h0);
    chk("arst_addr",   1, mem_addr[1], 32'h0);
    chk("arst_if_rd",  1, if_rdata[1], 32'h0);
    chk("arst_ls_rd",  1, ls_rdata[1], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("arst_no_rvalid", 1, 32'(if_rvalid[1]), 32'h0);
    end
    lit_txn(1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 4);

    // Random traffic on all lanes with one reset pulse in the middle
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n == 1500) rst = 1'b1;
      if (n == 1502) rst = 1'b0;
      for (int l = 0; l < NL; l++) begin
        if (if_req[l]) begin
          if (if_gnt[l]) begin
            if ($urandom_range(0, 1) == 0) if_req[l] = 1'b0;
            else if_addr[l] = rand_addr();
          end
        end else if ($urandom_range(0, 2) == 0) begin
          if_req[l] = 1'b1; if_addr[l] = rand_addr();
        end
        if (ls_req[l]) begin
          if (ls_gnt[l]) begin
            if ($urandom_range(0, 1) == 0) ls_req[l] = 1'b0;
            else begin
              ls_rw[l] = 1'($urandom_range(0, 1)); ls_addr[l] = rand_addr(); ls_wdata[l] = $urandom;
            end
          end
        end else if ($urandom_range(0, 2) == 0) begin
          ls_req[l] = 1'b1; ls_rw[l] = 1'($urandom_range(0, 1));
          ls_addr[l] = rand_addr(); ls_wdata[l] = $urandom;
        end
      end
    end
    for (int l = 0; l < NL; l++) begin
      if_req[l] = 1'b0; ls_req[l] = 1'b0;
    end
    repeat (12) @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/umem_port_arbiter.md
Name: umem_port_arbiter

Overview:
- Sequences and shares the single data-memory port (umem) between two requesters: the instruction-fetch path (IF) and the load/store path (LS).
- Turns the current combinational single-cycle memory access into a registered, multi-cycle transaction with a req/gnt/rvalid handshake.
- Sits between the CPU control logic and umem. Exactly one transaction is outstanding at any time.

Parameters:
- ADDR_W, 32, address width of requesters and memory port.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the mem_en cycle until mem_rdata is valid; legal range 1..4.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- nreset  input  1  asynchronous, active-high reset (1 = reset asserted).
- if_req  input  1  IF read request; hold with if_addr stable until if_gnt.
- if_addr  input  ADDR_W  IF read address.
- if_gnt  output  1  one-cycle pulse; IF request accepted.
- if_rvalid  output  1  one-cycle pulse; if_rdata valid.
- if_rdata  output  DATA_W  IF read data.
- ls_req  input  1  LS request; hold with ls_rw, ls_addr and ls_wdata stable until ls_gnt.
- ls_rw  input  1  0 = read, 1 = write.
- ls_addr  input  ADDR_W  LS address.
- ls_wdata  input  DATA_W  LS write data.
- ls_gnt  output  1  one-cycle pulse; LS request accepted.
- ls_rvalid  output  1  one-cycle pulse; read data valid, or write completed.
- ls_rdata  output  DATA_W  LS read data; 0 on write completion.
- mem_en  output  1  memory access strobe, high for exactly one cycle per transaction.
- mem_rw  output  1  to umem: 0 = read, 1 = write.
- mem_addr  output  ADDR_W  to umem.
- mem_wdata  output  DATA_W  to umem.
- mem_rdata  input  DATA_W  from umem; valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; state = IDLE; wait counter = 0; last_winner = IF.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise arbitrate among the requests that are high and sample the winner's command.
  - Next state is ISSUE.
- Arbitration: round-robin on last_winner.
  - On a conflict, the requester that did not win last time wins.
  - After reset, the first conflict goes to LS.
  - last_winner updates only on a grant.
- ISSUE (1 cycle):
  - Winner's gnt = 1, mem_en = 1.
  - mem_rw, mem_addr and mem_wdata carry the sampled command; mem_wdata = 0 for reads.
  - For a read, load the counter with MEM_LAT and go to WAIT.
  - For a write, go to DONE. The write commits in the ISSUE cycle and there is no WAIT.
- WAIT:
  - mem_en = 0. mem_addr/mem_rw hold their values; mem_wdata holds.
  - Counter decrements every cycle.
  - In the cycle the counter reaches 1, capture mem_rdata into the winner's rdata register and go to DONE.
- DONE (1 cycle):
  - Winner's rvalid = 1, with its rdata valid.
  - rdata keeps its value until that requester's next rvalid.
  - Next state is IDLE. No arbitration happens in DONE.
- Latency, request sampled in cycle 0:
  - Read: gnt in cycle 1, rvalid in cycle MEM_LAT+2.
  - Write: gnt in cycle 1, rvalid in cycle 2.
  - Back-to-back spacing: MEM_LAT+3 cycles per read, 3 per write.
- A request that stays high after its gnt is treated as a new request in the next IDLE.
- The loser's request stays pending; it is not dropped or latched.
- A request raised outside IDLE is ignored until IDLE.
- gnt and rvalid are never both high for the same requester in the same cycle. Never more than one gnt, and never more than one rvalid, is high per cycle.
- Reset asserted mid-transaction:
  - Outputs go to 0 immediately (asynchronous). State returns to IDLE.
  - The in-flight access is abandoned; no rvalid is ever generated for it.
- Writes use full word width. Byte/half sizing is handled by the requester.

Test Plan:
- Single IF read, MEM_LAT=2, if_addr=0x10, memory returns 0xDEADBEEF: if_gnt in cycle 1, mem_en=1 with mem_addr=0x10 and mem_rw=0 in cycle 1, if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 4, IDLE in cycle 5.
- LS write, ls_addr=0x20, ls_wdata=0x12345678: ls_gnt and mem_en with mem_rw=1, mem_addr=0x20, mem_wdata=0x12345678 in cycle 1; ls_rvalid=1 with ls_rdata=0 in cycle 2.
- Both requests held continuously from reset release: grants alternate LS, IF, LS, IF; each read completes before the next gnt; never two gnt pulses in one cycle.
- Read-after-write to 0x20: LS write 0xA5A5A5A5, then LS read 0x20 → ls_rdata=0xA5A5A5A5.
- Reset asserted in WAIT (cycle 2 of an IF read): all outputs 0 the same cycle; after release, no if_rvalid appears and a new if_req is granted normally.
- MEM_LAT=1 and MEM_LAT=4 sweep: read rvalid lands exactly in cycle 3 and cycle 6 respectively.
